// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and constants for the arithmetic library.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int SUB_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/serial_sub_32b_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_32b_if
// Description : Start/busy/done operand and result bundle for serial_sub_32b.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_sub_32b_if
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_W_DEFAULT
);
    logic             in_start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic [WIDTH-1:0] out_d;
    logic             out_b;
    logic             out_v;
    logic             out_busy;
    logic             out_done;

    // The sequencing controller side
    modport master (
        output in_start, in_a, in_b, in_c,
        input  out_d, out_b, out_v, out_busy, out_done
    );

    // The subtractor side
    modport slave (
        input  in_start, in_a, in_b, in_c,
        output out_d, out_b, out_v, out_busy, out_done
    );
endinterface : serial_sub_32b_if
`default_nettype wire

// File: rtl/full_sub_1b.sv
`default_nettype none
// ============================================================================
// Module      : full_sub_1b
// Description : Combinational 1-bit full subtractor, d = a - b - c.
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_1b (
    output logic out_d,
    output logic out_b,
    input  wire  in_a,
    input  wire  in_b,
    input  wire  in_c
);
    logic w_xy;

    assign w_xy  = in_a ^ in_b;
    assign out_d = w_xy ^ in_c;
    assign out_b = (~in_a & in_b) | (~w_xy & in_c);
endmodule : full_sub_1b
`default_nettype wire

// File: rtl/serial_sub_32b.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_32b
// Description : Bit-serial subtractor D = A - B - Bin, LSB first, WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_32b
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_W_DEFAULT
) (
    input wire              in_clk,
    input wire              in_rst,
    serial_sub_32b_if.slave bus
);
    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_sub_32b: WIDTH must be at least 2");
    end

    sub_state_t         r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_d;
    logic               r_bo;
    logic               r_v;
    logic               r_busy;
    logic               r_done;

    logic w_d;
    logic w_bo;

    full_sub_1b u_cell (
        .out_d (w_d),
        .out_b (w_bo),
        .in_a  (r_sa[0]),
        .in_b  (r_sb[0]),
        .in_c  (r_br)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.in_start) begin
                        r_sa    <= bus.in_a;
                        r_sb    <= bus.in_b;
                        r_br    <= bus.in_c;
                        // Sign bits are kept aside: shifting consumes the operands
                        r_a_msb <= bus.in_a[WIDTH-1];
                        r_b_msb <= bus.in_b[WIDTH-1];
                        r_cnt   <= '0;
                        r_d     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_d   <= {w_d, r_d[WIDTH-1:1]};
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_bo    <= w_bo;
                        r_v     <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_d    = r_d;
    assign bus.out_b    = r_bo;
    assign bus.out_v    = r_v;
    assign bus.out_busy = r_busy;
    assign bus.out_done = r_done;
endmodule : serial_sub_32b
`default_nettype wire

// File: tb/tb_serial_sub_32b.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_32b
// Description : Scoreboard testbench for serial_sub_32b with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_32b;
    import arith_pkg::*;

    localparam int WIDTH = 32;
    localparam int LIMIT = 40;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             b;
        logic             v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_sub_32b_if #(.WIDTH(WIDTH)) bus ();

    serial_sub_32b #(.WIDTH(WIDTH)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus.slave)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!rst && bus.out_done) begin
            exp_t e;
            n_done++;
            check("busy_during_done", {31'd0, bus.out_busy}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done pulse, expected none (d=0x%08h)", bus.out_d);
            end else begin
                e = sb_q.pop_front();
                check("result_d", bus.out_d, e.d);
                check("result_borrow", {31'd0, bus.out_b}, {31'd0, e.b});
                check("result_ovf", {31'd0, bus.out_v}, {31'd0, e.v});
            end
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_start = 1'b1;
        @(posedge clk);
        #1 bus.in_start = 1'b0;
    endtask

    // Counts negedges until done; optionally pulses stray starts at busy cycles 1 and 10
    task automatic wait_done(input bit inject, output int lat, output int busy_cnt);
        bit seen = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!seen && lat < LIMIT) begin
            @(negedge clk);
            lat++;
            if (bus.out_done) begin
                seen = 1'b1;
            end else begin
                if (bus.out_busy) busy_cnt++;
                if (inject && (lat == 1 || lat == 10)) begin
                    bus.in_a     = 32'hFFFF_FFFF;
                    bus.in_b     = 32'h0000_1234;
                    bus.in_c     = 1'b1;
                    bus.in_start = 1'b1;
                    @(posedge clk);
                    #1 bus.in_start = 1'b0;
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", LIMIT);
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic ev, input bit inject);
        int lat, busy_cnt, done_before;
        done_before = n_done;
        sb_q.push_back('{d: ed, b: eb, v: ev});
        start_op(a, b, c);
        wait_done(inject, lat, busy_cnt);
        check("latency", lat, WIDTH + 1);
        check("busy_cycles", busy_cnt, WIDTH);
        repeat (2) @(negedge clk);
        check("single_done", n_done - done_before, 1);
        check("hold_d", bus.out_d, ed);
        check("idle_busy", {31'd0, bus.out_busy}, 32'd0);
    endtask

    initial begin
        int lat, busy_cnt, done_before;
        bus.in_start = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_c     = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_d", bus.out_d, 32'd0);
        check("rst_b", {31'd0, bus.out_b}, 32'd0);
        check("rst_v", {31'd0, bus.out_v}, 32'd0);
        check("rst_busy", {31'd0, bus.out_busy}, 32'd0);
        check("rst_done", {31'd0, bus.out_done}, 32'd0);

        do_op(32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        do_op(32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        do_op(32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        do_op(32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        do_op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

        // Abort with reset at busy cycle 12; borrow/overflow from the last op are still set
        done_before = n_done;
        start_op(32'h0000_0100, 32'd1, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_d", bus.out_d, 32'd0);
        check("abort_b", {31'd0, bus.out_b}, 32'd0);
        check("abort_v", {31'd0, bus.out_v}, 32'd0);
        check("abort_busy", {31'd0, bus.out_busy}, 32'd0);
        check("abort_done", {31'd0, bus.out_done}, 32'd0);
        rst = 1'b0;
        repeat (LIMIT) @(negedge clk);
        check("abort_no_done", n_done - done_before, 0);

        // Stray starts while busy must not disturb the operation
        do_op(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);

        // Back-to-back: second start issued during the done cycle
        sb_q.push_back('{d: 32'hFFFF_FFFE, b: 1'b0, v: 1'b0});
        start_op(32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_done(1'b0, lat, busy_cnt);
        check("b2b_lat1", lat, WIDTH + 1);
        sb_q.push_back('{d: 32'h0FFF_FFFF, b: 1'b0, v: 1'b0});
        bus.in_a     = 32'h1234_5678;
        bus.in_b     = 32'h0234_5679;
        bus.in_c     = 1'b0;
        bus.in_start = 1'b1;
        @(posedge clk);
        #1 bus.in_start = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'd0, bus.out_busy}, 32'd1);
        wait_done(1'b0, lat, busy_cnt);
        check("b2b_lat2", lat, WIDTH);
        check("b2b_busy_cycles", busy_cnt, WIDTH - 1);
        repeat (2) @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_serial_sub_32b
`default_nettype wire
